sram: RTL and testbench

- Single-port 2048 x 8 static RAM model with a shared bidirectional 8-bit data bus, an active-low chip enable, and a read/write select.
- Used as a bus-attached scratch memory. An external master drives the data bus during writes. The RAM drives the bus during reads and otherwise leaves it high-impedance.
- Clocked: writes and read sampling occur on the rising edge of clk. Asynchronous active-high reset.

---
 rtl/sram_if.sv | 28 ++
 rtl/sram.sv | 43 ++++
 tb/tb_sram.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sram_if.sv
// Bus bundle for the scratch RAM: one shared bidirectional data bus plus the control lines.
// The two tri-state drivers live here so the RAM and the master each just supply an enable and a value.
interface sram_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
);
  wire  [DATA_WIDTH-1:0] data;
  logic                  readWrite;
  logic                  enable;
  logic [ADDR_WIDTH-1:0] address;
  logic                  mst_drv;
  logic [DATA_WIDTH-1:0] mst_dout;
  logic                  ram_oe;
  logic [DATA_WIDTH-1:0] ram_dout;

  assign data = mst_drv ? mst_dout : 'z;
  assign data = ram_oe  ? ram_dout : 'z;

  modport master (
    output readWrite, enable, address, mst_drv, mst_dout,
    input  data, ram_oe
  );

  modport slave (
    input  readWrite, enable, address, data,
    output ram_oe, ram_dout
  );
endinterface

// File: rtl/sram.sv
// Single-port DEPTH x DATA_WIDTH RAM on a shared bus: registered read, write on rising clk,
// bus released whenever the RAM is not selected for a read or reset is high.
module sram #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input logic   clk,
  input logic   reset,
  sram_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  in_range;
  logic                  wr_en;
  logic                  rd_en;

  assign in_range = ({1'b0, bus.address} < DEPTH_L);
  assign wr_en    = !bus.enable && bus.readWrite;
  assign rd_en    = !bus.enable && !bus.readWrite;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en && in_range) begin
      mem[bus.address] <= bus.data;
    end
  end

  // Out-of-range reads return zero rather than aliasing onto a real word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q <= '0;
    end else if (rd_en) begin
      rd_q <= in_range ? mem[bus.address] : '0;
    end
  end

  assign bus.ram_oe   = !reset && rd_en;
  assign bus.ram_dout = rd_q;
endmodule

// File: tb/tb_sram.sv
// Self-checking bench for sram: scoreboard of expected read data plus a vector table
// and hand-written sequences for reset, bus direction and address-change timing.
module tb_sram;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  sram_if #(.ADDR_WIDTH(11), .DATA_WIDTH(8)) bus ();

  sram #(.ADDR_WIDTH(11), .DATA_WIDTH(8), .DEPTH(2048)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [10:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp;
    string       name;
  } vec_t;

  typedef struct {
    logic [10:0] addr;
    logic [7:0]  exp;
    string       name;
  } sb_t;

  sb_t  sbq[$];
  vec_t vecs[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic chk_oe(input string name, input logic req);
    checks++;
    if (bus.ram_oe !== req) begin
      failures++;
      $display("FAIL %s: ram drive %b expected %b", name, bus.ram_oe, req);
    end
  endtask

  task automatic do_write(input logic [10:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.enable    = 1'b0;
    bus.readWrite = 1'b1;
    bus.address   = a;
    bus.mst_drv   = 1'b1;
    bus.mst_dout  = d;
    @(posedge clk);
  endtask

  // Issue a read, queue its expectation, and compare after the sampling edge.
  task automatic do_read(input logic [10:0] a, input logic [7:0] e, input string name);
    sb_t s;
    @(negedge clk);
    bus.mst_drv   = 1'b0;
    bus.enable    = 1'b0;
    bus.readWrite = 1'b0;
    bus.address   = a;
    s.addr = a; s.exp = e; s.name = name;
    sbq.push_back(s);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      s = sbq.pop_front();
      chk_oe({s.name, "_drive"}, 1'b1);
      chk(s.name, bus.data, s.exp);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.mst_drv   = 1'b0;
    bus.enable    = 1'b1;
    bus.readWrite = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    bus.enable = 1'b1; bus.readWrite = 1'b0; bus.address = '0;
    bus.mst_drv = 1'b0; bus.mst_dout = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_oe("reset_no_drive", 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Reset contents
    do_read(11'd0,    8'h00, "rst_addr0");
    do_read(11'd5,    8'h00, "rst_addr5");
    do_read(11'd2047, 8'h00, "rst_addr2047");

    // Asynchronous reset mid-cycle releases the bus at once
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk_oe("async_reset_release", 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Chip-enable gating: deselected writes must not land
    @(negedge clk);
    bus.enable = 1'b1; bus.readWrite = 1'b1; bus.address = 11'd10;
    bus.mst_drv = 1'b1; bus.mst_dout = 8'h3C;
    repeat (3) @(posedge clk);
    do_read(11'd10, 8'h00, "enable_gated_write");

    // Bus direction
    @(negedge clk);
    bus.enable = 1'b0; bus.readWrite = 1'b1; bus.address = 11'd20;
    bus.mst_drv = 1'b1; bus.mst_dout = 8'hA5;
    #1;
    chk_oe("write_mode_no_drive", 1'b0);
    chk("write_mode_bus_value", bus.data, 8'hA5);
    @(negedge clk);
    bus.mst_drv = 1'b0; bus.enable = 1'b1; bus.readWrite = 1'b0;
    #1;
    chk_oe("deselect_read_no_drive", 1'b0);
    bus.readWrite = 1'b1;
    #1;
    chk_oe("deselect_write_no_drive", 1'b0);
    do_read(11'd20, 8'hA5, "dir_read_back");

    // Pattern fill and readback
    for (int i = 0; i < 128; i++) do_write(11'(i), 8'(127 - i));
    for (int i = 0; i < 128; i++) do_read(11'(i), 8'(127 - i), $sformatf("pattern_%0d", i));

    // Address change during a read: old rd_q until the next edge
    do_read(11'd0, 8'd127, "addr_chg_first");
    @(negedge clk);
    bus.address = 11'd1;
    #1;
    chk("addr_chg_hold", bus.data, 8'd127);
    @(posedge clk); #1;
    chk("addr_chg_new", bus.data, 8'd126);

    // Deselected: rd_q holds across idle cycles
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.enable = 1'b0;
    #1;
    chk("rdq_hold_deselect", bus.data, 8'd126);

    // Boundary / overwrite / write-then-read vectors
    vecs.push_back('{1'b1, 11'd2047, 8'hFF, 8'h00, "w2047"});
    vecs.push_back('{1'b1, 11'd0,    8'h11, 8'h00, "w0a"});
    vecs.push_back('{1'b1, 11'd0,    8'h22, 8'h00, "w0b"});
    vecs.push_back('{1'b0, 11'd2047, 8'h00, 8'hFF, "r2047"});
    vecs.push_back('{1'b0, 11'd0,    8'h00, 8'h22, "r0_overwrite"});
    vecs.push_back('{1'b1, 11'd5,    8'h9C, 8'h00, "w5"});
    vecs.push_back('{1'b0, 11'd5,    8'h00, 8'h9C, "r5_next_edge"});
    vecs.push_back('{1'b1, 11'd1024, 8'h5A, 8'h00, "w1024"});
    vecs.push_back('{1'b0, 11'd1024, 8'h00, 8'h5A, "r1024"});
    vecs.push_back('{1'b0, 11'd127,  8'h00, 8'h00, "r127_pattern"});
    foreach (vecs[k]) begin
      if (vecs[k].rw) do_write(vecs[k].addr, vecs[k].wdata);
      else            do_read(vecs[k].addr, vecs[k].exp, vecs[k].name);
    end

    // Reset during a read after a write
    do_write(11'd3, 8'h55);
    do_read(11'd3, 8'h55, "r3_before_reset");
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk_oe("reset_mid_read_release", 1'b0);
    @(posedge clk); #1;
    chk_oe("reset_held_no_drive", 1'b0);
    @(negedge clk);
    reset = 1'b0;
    do_read(11'd3,    8'h00, "r3_after_reset");
    do_read(11'd2047, 8'h00, "r2047_after_reset");

    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
